// File: rtl/checkpoint_seq_monitor_pkg.sv
// Shared types and constants for the checkpoint sequence monitor.
// The state enum is also exported on the bus for observation.
package checkpoint_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } mon_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_MISMATCH = 2'd2;
  localparam logic [1:0] FC_MISSING  = 2'd3;

  localparam logic [15:0] DEF_START_MARK = 16'hAB40;
  localparam logic [15:0] DEF_END_MARK   = 16'hAB51;

endpackage

// File: rtl/checkpoint_seq_monitor_if.sv
// Status-bus, configuration and result signals of the checkpoint monitor.
// The master side drives stimulus and configuration; the slave side is the monitor.
interface checkpoint_seq_monitor_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
);
  import checkpoint_mon_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  // There is no backpressure anywhere: cfg_we is a one-cycle write strobe that
  // lands only while busy is low, and arm is a one-cycle pulse honoured only
  // while busy is low. Results are level outputs except cp_hit (one-cycle pulse).
  logic [DATA_W-1:0] checkbits;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [LW-1:0]     cfg_len;
  logic              arm;
  logic              busy;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [CNT_W-1:0]  cycles;
  logic [LW-1:0]     cp_idx;
  logic              cp_hit;
  logic [CNT_W-1:0]  cp_stamp;
  mon_state_e        state_dbg;

  modport master (
    output checkbits, cfg_we, cfg_addr, cfg_data, cfg_len, arm,
    input  busy, pass, fail, fail_code, cycles, cp_idx, cp_hit, cp_stamp, state_dbg
  );

  modport slave (
    input  checkbits, cfg_we, cfg_addr, cfg_data, cfg_len, arm,
    output busy, pass, fail, fail_code, cycles, cp_idx, cp_hit, cp_stamp, state_dbg
  );

endinterface

// File: rtl/checkpoint_seq_monitor_change_det.sv
// Two-stage register on the status bus; flags a change when the newest
// sample differs from the one before it.
module checkpoint_change_det #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] value,
  output logic              change
);

  logic [DATA_W-1:0] s0_q, s0_d;
  logic [DATA_W-1:0] s1_q, s1_d;

  always_comb begin
    s0_d = din;
    s1_d = s0_q;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign value  = s0_q;
  assign change = (s0_q != s1_q);

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Watches the status bus for a start marker, then matches an ordered list of
// programmed checkpoint values until the end marker or a timeout.
module checkpoint_seq_monitor
  import checkpoint_mon_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 8,
  parameter int                CNT_W      = 32,
  parameter int                TIMEOUT    = 250000,
  parameter logic [DATA_W-1:0] START_MARK = DEF_START_MARK,
  parameter logic [DATA_W-1:0] END_MARK   = DEF_END_MARK,
  parameter bit                STRICT     = 1'b0
) (
  input logic                   clock,
  input logic                   resetb,
  checkpoint_seq_monitor_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] s_val;
  logic              s_chg;

  checkpoint_change_det #(.DATA_W(DATA_W)) u_det (
    .clock  (clock),
    .resetb (resetb),
    .din    (bus.checkbits),
    .value  (s_val),
    .change (s_chg)
  );

  mon_state_e        state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [1:0]        code_q, code_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  stamp_q, stamp_d;
  logic [DATA_W-1:0] exp_q [DEPTH];
  logic [DATA_W-1:0] exp_d [DEPTH];

  logic              busy;
  logic              tmo_hit;
  logic              ended;
  logic [CNT_W-1:0]  cyc_inc;

  assign busy    = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT - 1));
  assign cyc_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    code_d   = code_q;
    cycles_d = cycles_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    hit_d    = 1'b0;
    stamp_d  = stamp_q;
    exp_d    = exp_q;
    ended    = 1'b0;

    // The expected list is frozen for the whole session.
    if (bus.cfg_we && !busy) exp_d[bus.cfg_addr] = bus.cfg_data;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (bus.arm) begin
          state_d  = ST_ARMED;
          len_d    = (bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          code_d   = FC_NONE;
          cycles_d = '0;
          idx_d    = '0;
          tmo_d    = '0;
        end
      end
      ST_ARMED: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (s_chg && (s_val == START_MARK)) begin
          state_d  = ST_RUN;
          cycles_d = '0;
        end else if (tmo_hit) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          code_d  = FC_TIMEOUT;
        end
      end
      ST_RUN: begin
        tmo_d    = tmo_q + CNT_W'(1);
        cycles_d = cyc_inc;
        if (s_chg) begin
          if (s_val == END_MARK) begin
            ended = 1'b1;
            if (idx_q == len_q) begin
              state_d = ST_PASS;
              pass_d  = 1'b1;
            end else begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = FC_MISSING;
            end
          end else if ((idx_q < len_q) && (s_val == exp_q[idx_q[AW-1:0]])) begin
            hit_d   = 1'b1;
            stamp_d = cyc_inc;
            idx_d   = idx_q + LW'(1);
          end else if (STRICT) begin
            ended   = 1'b1;
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = FC_MISMATCH;
          end
        end
        // A terminating event on the same edge as the timeout takes precedence.
        if (tmo_hit && !ended) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          code_d  = FC_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= FC_NONE;
      cycles_q <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      stamp_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      cycles_q <= cycles_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      stamp_q  <= stamp_d;
    end
  end

  // Expected values survive reset so a bench can program once and rerun.
  always_ff @(posedge clock) begin
    exp_q <= exp_d;
  end

  assign bus.busy      = busy;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = code_q;
  assign bus.cycles    = cycles_q;
  assign bus.cp_idx    = idx_q;
  assign bus.cp_hit    = hit_q;
  assign bus.cp_stamp  = stamp_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: three instances (lenient, strict, short timeout)
// share one stimulus bus; directed scenarios plus randomized runs against a model.
module tb_checkpoint_seq_monitor;
  import checkpoint_mon_pkg::*;

  localparam logic [15:0] START = 16'hAB40;
  localparam logic [15:0] ENDM  = 16'hAB51;

  logic        clk = 1'b0;
  logic        resetb;
  logic [15:0] checkbits;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [3:0]  cfg_len;
  logic        arm;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int arm_edge = 0;

  logic [15:0] exp_arr [8];
  logic [31:0] obs_n [$];
  logic [31:0] obs_s [$];
  logic [15:0] scen_v [$];
  int          scen_c [$];

  bit          m_pass, m_fail;
  int          m_code, m_idx, m_len;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  checkpoint_seq_monitor_if #(.DATA_W(16), .DEPTH(8), .CNT_W(32)) if_n ();
  checkpoint_seq_monitor_if #(.DATA_W(16), .DEPTH(8), .CNT_W(32)) if_s ();
  checkpoint_seq_monitor_if #(.DATA_W(16), .DEPTH(8), .CNT_W(32)) if_t ();

  assign if_n.checkbits = checkbits; assign if_s.checkbits = checkbits; assign if_t.checkbits = checkbits;
  assign if_n.cfg_we = cfg_we;       assign if_s.cfg_we = cfg_we;       assign if_t.cfg_we = cfg_we;
  assign if_n.cfg_addr = cfg_addr;   assign if_s.cfg_addr = cfg_addr;   assign if_t.cfg_addr = cfg_addr;
  assign if_n.cfg_data = cfg_data;   assign if_s.cfg_data = cfg_data;   assign if_t.cfg_data = cfg_data;
  assign if_n.cfg_len = cfg_len;     assign if_s.cfg_len = cfg_len;     assign if_t.cfg_len = cfg_len;
  assign if_n.arm = arm;             assign if_s.arm = arm;             assign if_t.arm = arm;

  checkpoint_seq_monitor #(.TIMEOUT(5000), .STRICT(1'b0)) dut_n (.clock(clk), .resetb(resetb), .bus(if_n));
  checkpoint_seq_monitor #(.TIMEOUT(5000), .STRICT(1'b1)) dut_s (.clock(clk), .resetb(resetb), .bus(if_s));
  checkpoint_seq_monitor #(.TIMEOUT(500),  .STRICT(1'b0)) dut_t (.clock(clk), .resetb(resetb), .bus(if_t));

  always @(negedge clk) begin
    if (if_n.cp_hit) obs_n.push_back(if_n.cp_stamp);
    if (if_s.cp_hit) obs_s.push_back(if_s.cp_stamp);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  task automatic program_all();
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = exp_arr[i];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] len);
    checkbits = 16'h0000;
    repeat (3) @(posedge clk);
    #1 cfg_len = len; arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    arm_edge = edge_n;
    obs_n.delete();
    obs_s.delete();
  endtask

  task automatic wait_to(input int c);
    while (edge_n - arm_edge < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_at(input int c, input logic [15:0] v);
    wait_to(c);
    checkbits = v;
  endtask

  // Event-level model: a value driven after edge c is judged at edge c+2;
  // a stamp is the distance from the start marker in drive cycles.
  task automatic model_run(input bit strict, input int tmo);
    logic [15:0] prev, v;
    bit run, done;
    int cs, ev;
    m_pass = 0; m_fail = 0; m_code = 0; m_idx = 0; exp_q.delete();
    prev = 16'h0000; run = 0; done = 0; cs = 0;
    for (int k = 0; k < scen_v.size(); k++) begin
      v = scen_v[k];
      ev = scen_c[k] + 2;
      if (done || v == prev) continue;
      prev = v;
      if (ev > tmo) begin m_fail = 1; m_code = 1; done = 1; end
      else if (!run) begin
        if (v == START) begin run = 1; cs = scen_c[k]; end
      end else if (v == ENDM) begin
        if (m_idx == m_len) m_pass = 1;
        else begin m_fail = 1; m_code = 3; end
        done = 1;
      end else if (m_idx < m_len && v == exp_arr[m_idx]) begin
        exp_q.push_back(32'(scen_c[k] - cs));
        m_idx++;
      end else if (strict) begin
        m_fail = 1; m_code = 2; done = 1;
      end
    end
    if (!done) begin m_fail = 1; m_code = 1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetb = 1'b0; checkbits = 16'h0000; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; cfg_len = '0; arm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (if_n.state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset.state got=%0d want=%0d", if_n.state_dbg, ST_IDLE); end
    total++; if ({if_n.busy, if_n.pass, if_n.fail, if_n.cp_hit} !== 4'b0) begin bad++; $display("FAIL reset.flags got=%b want=0000", {if_n.busy, if_n.pass, if_n.fail, if_n.cp_hit}); end
    total++; if ({if_n.fail_code, if_n.cycles, if_n.cp_idx, if_n.cp_stamp} !== '0) begin bad++; $display("FAIL reset.values code=%0d cycles=%0d idx=%0d stamp=%0d want all 0", if_n.fail_code, if_n.cycles, if_n.cp_idx, if_n.cp_stamp); end
    total++; if ({if_s.busy, if_t.busy, if_s.fail, if_t.fail} !== 4'b0) begin bad++; $display("FAIL reset.others got=%b want=0000", {if_s.busy, if_t.busy, if_s.fail, if_t.fail}); end
    resetb = 1'b1;
  endtask

  task automatic test_pass_seq();
    exp_arr = '{16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    program_all();
    do_arm(4'd4);
    total++; if (if_n.busy !== 1'b1 || if_n.state_dbg !== ST_ARMED) begin bad++; $display("FAIL pass_seq.armed busy=%b state=%0d want busy=1 state=ARMED", if_n.busy, if_n.state_dbg); end
    drive_at(1, START);
    for (int i = 0; i < 4; i++) drive_at(101 + 100 * i, exp_arr[i]);
    drive_at(501, ENDM);
    wait_to(506);
    total++; if (obs_n.size() != 4) begin bad++; $display("FAIL pass_seq.hits got=%0d want=4", obs_n.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (obs_n[i] !== 32'(100 * (i + 1))) begin bad++; $display("FAIL pass_seq.stamp%0d got=%0d want=%0d", i, obs_n[i], 100 * (i + 1)); end
    end
    total++; if (if_n.pass !== 1'b1 || if_n.fail !== 1'b0 || if_n.fail_code !== 2'd0) begin bad++; $display("FAIL pass_seq.result pass=%b fail=%b code=%0d want 1 0 0", if_n.pass, if_n.fail, if_n.fail_code); end
    total++; if (if_n.cp_idx !== 4'd4) begin bad++; $display("FAIL pass_seq.cp_idx got=%0d want=4", if_n.cp_idx); end
    total++; if (if_n.cycles !== 32'd500) begin bad++; $display("FAIL pass_seq.cycles got=%0d want=500", if_n.cycles); end
    total++; if (if_s.pass !== 1'b1) begin bad++; $display("FAIL pass_seq.strict_pass got=%b want=1", if_s.pass); end
  endtask

  task automatic test_missing();
    do_arm(4'd4);
    drive_at(1, START);
    drive_at(51, 16'h003E);
    drive_at(101, ENDM);
    wait_to(106);
    total++; if (if_n.fail !== 1'b1 || if_n.pass !== 1'b0 || if_n.fail_code !== FC_MISSING) begin bad++; $display("FAIL missing.result fail=%b pass=%b code=%0d want 1 0 3", if_n.fail, if_n.pass, if_n.fail_code); end
    total++; if (if_n.cp_idx !== 4'd1) begin bad++; $display("FAIL missing.cp_idx got=%0d want=1", if_n.cp_idx); end
    total++; if (obs_n.size() != 1 || obs_n[0] !== 32'd50) begin bad++; $display("FAIL missing.stamp hits=%0d want one hit at 50", obs_n.size()); end
  endtask

  task automatic test_strict();
    do_arm(4'd4);
    drive_at(1, START);
    drive_at(21, 16'h1234);
    wait_to(22);
    total++; if (if_s.fail !== 1'b0 || if_s.busy !== 1'b1) begin bad++; $display("FAIL strict.early fail=%b busy=%b want 0 1", if_s.fail, if_s.busy); end
    wait_to(23);
    total++; if (if_s.fail !== 1'b1 || if_s.fail_code !== FC_MISMATCH || if_s.busy !== 1'b0) begin bad++; $display("FAIL strict.mismatch fail=%b code=%0d busy=%b want 1 2 0", if_s.fail, if_s.fail_code, if_s.busy); end
    wait_to(30);
    total++; if (if_n.busy !== 1'b1 || if_n.fail !== 1'b0) begin bad++; $display("FAIL strict.lenient busy=%b fail=%b want 1 0", if_n.busy, if_n.fail); end
    drive_at(31, ENDM);
    wait_to(35);
  endtask

  task automatic test_timeout();
    do_arm(4'd4);
    wait_to(499);
    total++; if (if_t.fail !== 1'b0 || if_t.busy !== 1'b1) begin bad++; $display("FAIL timeout.early fail=%b busy=%b want 0 1", if_t.fail, if_t.busy); end
    wait_to(500);
    total++; if (if_t.fail !== 1'b1 || if_t.fail_code !== FC_TIMEOUT || if_t.pass !== 1'b0) begin bad++; $display("FAIL timeout.fire fail=%b code=%0d pass=%b want 1 1 0", if_t.fail, if_t.fail_code, if_t.pass); end
    do_arm(4'd0);
    drive_at(10, START);
    drive_at(498, ENDM);
    wait_to(499);
    total++; if (if_t.pass !== 1'b0 || if_t.busy !== 1'b1) begin bad++; $display("FAIL timeout.race_early pass=%b busy=%b want 0 1", if_t.pass, if_t.busy); end
    wait_to(500);
    total++; if (if_t.pass !== 1'b1 || if_t.fail !== 1'b0 || if_t.fail_code !== FC_NONE) begin bad++; $display("FAIL timeout.race pass=%b fail=%b code=%0d want 1 0 0", if_t.pass, if_t.fail, if_t.fail_code); end
  endtask

  task automatic test_len0_rearm_reset();
    do_arm(4'd0);
    drive_at(1, START);
    drive_at(11, ENDM);
    wait_to(16);
    total++; if (if_n.pass !== 1'b1 || if_n.cp_idx !== 4'd0 || if_n.cycles !== 32'd10) begin bad++; $display("FAIL len0.result pass=%b idx=%0d cycles=%0d want 1 0 10", if_n.pass, if_n.cp_idx, if_n.cycles); end
    do_arm(4'd0);
    total++; if (if_n.pass !== 1'b0 || if_n.busy !== 1'b1 || if_n.cycles !== 32'd0 || if_n.state_dbg !== ST_ARMED) begin bad++; $display("FAIL rearm.clear pass=%b busy=%b cycles=%0d state=%0d", if_n.pass, if_n.busy, if_n.cycles, if_n.state_dbg); end
    drive_at(1, START);
    wait_to(3);
    total++; if (if_n.state_dbg !== ST_RUN || if_n.cycles !== 32'd0) begin bad++; $display("FAIL rearm.start state=%0d cycles=%0d want RUN 0", if_n.state_dbg, if_n.cycles); end
    wait_to(13);
    total++; if (if_n.cycles !== 32'd10) begin bad++; $display("FAIL rearm.count got=%0d want=10", if_n.cycles); end
    resetb = 1'b0;
    @(posedge clk); #1;
    total++; if (if_n.state_dbg !== ST_IDLE || {if_n.busy, if_n.pass, if_n.fail, if_n.cp_hit} !== 4'b0 || if_n.cycles !== 32'd0 || if_n.fail_code !== 2'd0) begin bad++; $display("FAIL midreset state=%0d busy=%b cycles=%0d want IDLE 0 0", if_n.state_dbg, if_n.busy, if_n.cycles); end
    resetb = 1'b1;
  endtask

  task automatic test_cfg_frozen();
    do_arm(4'd4);
    drive_at(1, START);
    drive_at(21, 16'h003E);
    wait_to(30);
    arm = 1'b1; @(posedge clk); #1 arm = 1'b0;
    total++; if (if_n.cp_idx !== 4'd1 || if_n.state_dbg !== ST_RUN) begin bad++; $display("FAIL frozen.arm_ignored idx=%0d state=%0d want 1 RUN", if_n.cp_idx, if_n.state_dbg); end
    wait_to(35);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'h7777;
    @(posedge clk); #1 cfg_we = 1'b0;
    drive_at(41, 16'h0044);
    drive_at(61, 16'h004A);
    drive_at(81, 16'h0050);
    drive_at(101, ENDM);
    wait_to(106);
    total++; if (if_n.pass !== 1'b1 || if_n.cp_idx !== 4'd4) begin bad++; $display("FAIL frozen.result pass=%b idx=%0d want 1 4", if_n.pass, if_n.cp_idx); end
    total++; if (obs_n.size() != 4 || obs_n[3] !== 32'd80) begin bad++; $display("FAIL frozen.stamps hits=%0d want 4 ending at 80", obs_n.size()); end
  endtask

  task automatic test_random();
    int raw, c;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int i = 0; i < 8; i++) exp_arr[i] = 16'($urandom_range(0, 255));
      program_all();
      raw = $urandom_range(0, 10);
      m_len = (raw > 8) ? 8 : raw;
      scen_v.delete(); scen_c.delete();
      c = 1 + $urandom_range(0, 3);
      scen_v.push_back(START); scen_c.push_back(c);
      for (int i = 0; i < m_len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          c += $urandom_range(1, 6);
          scen_v.push_back(($urandom_range(0, 7) == 0) ? START : 16'($urandom_range(0, 255)));
          scen_c.push_back(c);
        end
        if ($urandom_range(0, 7) != 0) begin
          c += $urandom_range(1, 6);
          scen_v.push_back(exp_arr[i]); scen_c.push_back(c);
        end
      end
      c += $urandom_range(1, 6);
      scen_v.push_back(ENDM); scen_c.push_back(c);
      do_arm(4'(raw));
      for (int k = 0; k < scen_v.size(); k++) drive_at(scen_c[k], scen_v[k]);
      wait_to(c + 5);
      for (int d = 0; d < 2; d++) begin
        model_run(d == 1, 5000);
        if (d == 0) begin
          total++; if ({if_n.pass, if_n.fail} !== {m_pass, m_fail} || int'(if_n.fail_code) != m_code || int'(if_n.cp_idx) != m_idx) begin bad++; $display("FAIL random%0d.lenient pass=%b fail=%b code=%0d idx=%0d want %b %b %0d %0d", it, if_n.pass, if_n.fail, if_n.fail_code, if_n.cp_idx, m_pass, m_fail, m_code, m_idx); end
          total++; if (obs_n != exp_q) begin bad++; $display("FAIL random%0d.lenient_stamps hits=%0d want=%0d", it, obs_n.size(), exp_q.size()); end
        end else begin
          total++; if ({if_s.pass, if_s.fail} !== {m_pass, m_fail} || int'(if_s.fail_code) != m_code || int'(if_s.cp_idx) != m_idx) begin bad++; $display("FAIL random%0d.strict pass=%b fail=%b code=%0d idx=%0d want %b %b %0d %0d", it, if_s.pass, if_s.fail, if_s.fail_code, if_s.cp_idx, m_pass, m_fail, m_code, m_idx); end
          total++; if (obs_s != exp_q) begin bad++; $display("FAIL random%0d.strict_stamps hits=%0d want=%0d", it, obs_s.size(), exp_q.size()); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_seq();
    test_missing();
    test_strict();
    test_timeout();
    test_len0_rearm_reset();
    test_cfg_frozen();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
- Parametrised, synthesizable monitor for the 16-bit management-to-user status bus (mprj_io[31:16] "checkbits").
- Waits for a start marker, then counts cycles and checks an ordered list of programmed checkpoint values. It finishes on an end marker or a timeout.
- Replaces hand-written wait/flag/cycle-count sequences in Caravel benches. Also usable on-chip as a self-test observer in the user project.

Parameters:
- DATA_W, 16, width of observed status bus
- DEPTH, 8, max number of programmable checkpoints
- CNT_W, 32, width of cycle and timeout counters
- TIMEOUT, 250000, cycles from arm to forced failure
- START_MARK, 16'hAB40, value that opens the run
- END_MARK, 16'hAB51, value that closes the run
- STRICT, 0, 1 = any unexpected new value fails; 0 = unexpected values ignored

Ports:
- clock  in  1  system clock
- resetb  in  1  synchronous active-low reset
- checkbits  in  DATA_W  observed status bus (asynchronous to firmware, stable per value)
- cfg_we  in  1  write expected value
- cfg_addr  in  $clog2(DEPTH)  checkpoint slot
- cfg_data  in  DATA_W  expected value
- cfg_len  in  $clog2(DEPTH+1)  number of checkpoints used; sampled on arm
- arm  in  1  single-cycle pulse that starts a monitoring session
- busy  out  1  high in ARMED or RUN
- pass  out  1  sticky success
- fail  out  1  sticky failure
- fail_code  out  2  0 none, 1 TIMEOUT, 2 MISMATCH, 3 MISSING
- cycles  out  CNT_W  cycles since start marker (saturating)
- cp_idx  out  $clog2(DEPTH+1)  checkpoints matched so far
- cp_hit  out  1  one-cycle pulse per matched checkpoint
- cp_stamp  out  CNT_W  value of cycles at the last hit

Behaviour:
- Reset (resetb=0 at posedge): state IDLE; all outputs 0; expected-value regs are not cleared.
- Input path: checkbits is registered into s0, then s1. A change event is s0!=s1. Decisions use s0, so latency is 2 cycles from pin to event.
- States:
  - IDLE: arm latches len=min(cfg_len,DEPTH), clears pass/fail/fail_code/cycles/cp_idx/timeout counter, then goes to ARMED.
  - ARMED: on a change event with s0==START_MARK, go to RUN and set cycles=0.
  - RUN: cycles increments every cycle and saturates at all-ones. Each change event is evaluated in this priority order:
    1. s0==END_MARK: if cp_idx==len, go to PASS; otherwise go to FAIL with code MISSING.
    2. cp_idx<len and s0==exp[cp_idx]: pulse cp_hit, set cp_stamp=cycles, increment cp_idx.
    3. Otherwise: if STRICT, go to FAIL with code MISMATCH; else ignore.
  - PASS / FAIL: hold all outputs. arm restarts from the IDLE actions.
- Timeout counter runs in ARMED and RUN. When it reaches TIMEOUT-1 with no other transition, go to FAIL with code TIMEOUT.
- Simultaneous events in one cycle:
  - RUN event evaluation beats timeout.
  - arm while busy is ignored.
  - cfg_we while busy is ignored, so the expected list is frozen during a run.
- START_MARK seen again inside RUN is treated as an ordinary value.
- len=0: START followed by END gives pass.
- Repeated identical value produces no event, because only changes are evaluated.
- resetb low mid-run aborts to IDLE with outputs cleared.
- busy = (state==ARMED || state==RUN). pass and fail are never both 1.

Decomposition:
- Shared package checkpoint_mon_pkg:
  - state enum {IDLE, ARMED, RUN, PASS, FAIL}
  - fail_code localparams
  - default START/END marks
- One natural sub-module: checkpoint_change_det. It holds the s0/s1 sync/edge register pair, is parametrised by DATA_W, and outputs value and change.

Test Plan:
- Program exp={003E,0044,004A,0050}, len=4, arm. Drive AB40, 003E, 0044, 004A, 0050, AB51 with 100-cycle gaps -> 4 cp_hit pulses, cp_stamp =100/200/300/400 (±0), pass=1, cp_idx=4, fail_code=0.
- Same list, drive AB40, 003E, AB51 -> fail=1, fail_code=3, cp_idx=1.
- STRICT=1, drive AB40, 1234 -> fail_code=2 two cycles after 1234 appears. With STRICT=0 the same stimulus keeps busy=1.
- TIMEOUT=500, arm and never drive START -> fail=1, fail_code=1 exactly 500 cycles after arm. With END arriving on that same cycle -> pass wins.
- len=0: AB40 then AB51 -> pass. Assert resetb low mid-RUN -> all outputs 0, state IDLE. A second arm after pass reruns cleanly with cycles restarting at 0.
- cfg_we during RUN with a different value -> ignored; original sequence still passes.
